// File: rtl/multi_way_matcher.sv
// Exact-match lookup engine: extracts a configurable key from packet memory,
// hashes it and linearly probes up to WAYS table entries for a valid match.
module multi_way_matcher #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned KEY_MAX  = 8,
  parameter int unsigned WAYS     = 4,
  parameter int unsigned HASH_W   = 16,
  parameter int unsigned PKT_BASE = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [5:0]        cfg_key_off_i,
  input  logic [3:0]        cfg_key_len_i,
  input  logic [7:0]        cfg_entry_len_i,
  input  logic [ADDR_W-1:0] cfg_base_i,
  input  logic [HASH_W-1:0] cfg_mask_i,
  output logic              mem_ce_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [7:0]        mem_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              hit_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] val_addr_o
);

  localparam int unsigned CNT_W  = $clog2(KEY_MAX + 2) + 1;
  localparam int unsigned P_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned SLICES = 64 / HASH_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_KEY,
    S_HASH,
    S_LOAD_ENTRY,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [P_W-1:0]           p_q, p_d;
  logic [HASH_W-1:0]        h_q, h_d;
  logic [ADDR_W-1:0]        ent_base_q, ent_base_d;
  logic [5:0]               off_q, off_d;
  logic [3:0]               len_q, len_d;
  logic [7:0]               stride_q, stride_d;
  logic [ADDR_W-1:0]        base_q, base_d;
  logic [HASH_W-1:0]        mask_q, mask_d;
  logic [KEY_MAX-1:0][7:0]  key_q, key_d;
  logic [KEY_MAX-1:0][7:0]  ent_q, ent_d;
  logic [7:0]               vld_q, vld_d;

  logic                     mem_ce_d;
  logic [ADDR_W-1:0]        mem_addr_d;
  logic                     busy_d, done_d, hit_d, err_d;
  logic [ADDR_W-1:0]        val_addr_d;

  logic [63:0]              key_packed;
  logic [HASH_W-1:0]        hash_c;
  logic                     key_match_c;

  // Entry address of a probe: index wraps inside the power-of-two table.
  function automatic logic [ADDR_W-1:0] probe_addr(
    input logic [ADDR_W-1:0] base,
    input logic [HASH_W-1:0] h,
    input logic [P_W-1:0]    p,
    input logic [HASH_W-1:0] mask,
    input logic [7:0]        stride
  );
    logic [HASH_W-1:0] idx;
    idx = (h + HASH_W'(p)) & mask;
    return base + ADDR_W'(idx) * ADDR_W'(stride);
  endfunction

  // Pack the key MSB-first and fold it into HASH_W bits by XOR.
  always_comb begin
    key_packed = '0;
    for (int i = 0; i < int'(KEY_MAX); i++) begin
      key_packed[63-8*i -: 8] = key_q[i];
    end
    hash_c = '0;
    for (int s = 0; s < int'(SLICES); s++) begin
      hash_c = hash_c ^ key_packed[s*HASH_W +: HASH_W];
    end
  end

  // Compare only the first len_q bytes of the fetched entry key.
  always_comb begin
    key_match_c = 1'b1;
    for (int i = 0; i < int'(KEY_MAX); i++) begin
      if ((32'(i) < 32'(len_q)) && (ent_q[i] != key_q[i])) begin
        key_match_c = 1'b0;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    p_d        = p_q;
    h_d        = h_q;
    ent_base_d = ent_base_q;
    off_d      = off_q;
    len_d      = len_q;
    stride_d   = stride_q;
    base_d     = base_q;
    mask_d     = mask_q;
    key_d      = key_q;
    ent_d      = ent_q;
    vld_d      = vld_q;
    hit_d      = hit_o;
    err_d      = err_o;
    val_addr_d = val_addr_o;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          off_d      = cfg_key_off_i;
          len_d      = cfg_key_len_i;
          stride_d   = cfg_entry_len_i;
          base_d     = cfg_base_i;
          mask_d     = cfg_mask_i;
          key_d      = '0;
          hit_d      = 1'b0;
          err_d      = 1'b0;
          val_addr_d = '0;
          cnt_d      = '0;
          if ((cfg_key_len_i == 4'd0) || (32'(cfg_key_len_i) > 32'(KEY_MAX))) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD_KEY;
          end
        end
      end

      S_LOAD_KEY: begin
        for (int i = 0; i < int'(KEY_MAX); i++) begin
          if (cnt_q == CNT_W'(i + 1)) key_d[i] = mem_data_i;
        end
        if (cnt_q == CNT_W'(len_q)) begin
          state_d = S_HASH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_HASH: begin
        h_d        = hash_c;
        p_d        = '0;
        ent_base_d = probe_addr(base_q, hash_c, '0, mask_q, stride_q);
        cnt_d      = '0;
        state_d    = S_LOAD_ENTRY;
      end

      S_LOAD_ENTRY: begin
        if (cnt_q == CNT_W'(1)) vld_d = mem_data_i;
        for (int i = 0; i < int'(KEY_MAX); i++) begin
          if (cnt_q == CNT_W'(i + 2)) ent_d[i] = mem_data_i;
        end
        if (cnt_q == CNT_W'(len_q) + CNT_W'(1)) begin
          state_d = S_COMPARE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_COMPARE: begin
        if ((vld_q != 8'd0) && key_match_c) begin
          hit_d      = 1'b1;
          val_addr_d = ent_base_q + ADDR_W'(len_q) + ADDR_W'(1);
          state_d    = S_DONE;
        end else if (vld_q == 8'd0) begin
          state_d = S_DONE;
        end else if ((32'(p_q) + 32'd1) < 32'(WAYS)) begin
          p_d        = p_q + P_W'(1);
          ent_base_d = probe_addr(base_q, h_q, p_q + P_W'(1), mask_q, stride_q);
          cnt_d      = '0;
          state_d    = S_LOAD_ENTRY;
        end else begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    mem_ce_d   = 1'b0;
    mem_addr_d = '0;
    if (state_d == S_LOAD_KEY) begin
      mem_ce_d   = (cnt_d < CNT_W'(len_d));
      mem_addr_d = ADDR_W'(PKT_BASE) + ADDR_W'(off_d) + ADDR_W'(cnt_d);
    end else if (state_d == S_LOAD_ENTRY) begin
      mem_ce_d   = (cnt_d <= CNT_W'(len_d));
      mem_addr_d = ent_base_d + ADDR_W'(cnt_d);
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      p_q        <= '0;
      h_q        <= '0;
      ent_base_q <= '0;
      off_q      <= '0;
      len_q      <= '0;
      stride_q   <= '0;
      base_q     <= '0;
      mask_q     <= '0;
      key_q      <= '0;
      ent_q      <= '0;
      vld_q      <= '0;
      mem_ce_o   <= 1'b0;
      mem_addr_o <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      hit_o      <= 1'b0;
      err_o      <= 1'b0;
      val_addr_o <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      p_q        <= p_d;
      h_q        <= h_d;
      ent_base_q <= ent_base_d;
      off_q      <= off_d;
      len_q      <= len_d;
      stride_q   <= stride_d;
      base_q     <= base_d;
      mask_q     <= mask_d;
      key_q      <= key_d;
      ent_q      <= ent_d;
      vld_q      <= vld_d;
      mem_ce_o   <= mem_ce_d;
      mem_addr_o <= mem_addr_d;
      busy_o     <= busy_d;
      done_o     <= done_d;
      hit_o      <= hit_d;
      err_o      <= err_d;
      val_addr_o <= val_addr_d;
    end
  end

endmodule

// File: tb/tb_multi_way_matcher.sv
// Scoreboard bench for multi_way_matcher: a behavioural table-lookup model
// predicts result, latency and read addresses; a monitor checks the DUT.
module tb_multi_way_matcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [5:0]  cfg_key_off_i;
  logic [3:0]  cfg_key_len_i;
  logic [7:0]  cfg_entry_len_i;
  logic [31:0] cfg_base_i;
  logic [15:0] cfg_mask_i;
  logic        mem_ce_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_data_i = 8'd0;
  logic        busy_o, done_o, hit_o, err_o;
  logic [31:0] val_addr_o;

  multi_way_matcher dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .cfg_key_off_i(cfg_key_off_i), .cfg_key_len_i(cfg_key_len_i),
    .cfg_entry_len_i(cfg_entry_len_i), .cfg_base_i(cfg_base_i),
    .cfg_mask_i(cfg_mask_i), .mem_ce_o(mem_ce_o), .mem_addr_o(mem_addr_o),
    .mem_data_i(mem_data_i), .busy_o(busy_o), .done_o(done_o),
    .hit_o(hit_o), .err_o(err_o), .val_addr_o(val_addr_o)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:4095];

  // One-cycle read latency memory.
  always @(posedge clk) if (mem_ce_o) mem_data_i <= mem[mem_addr_o[11:0]];

  typedef struct {
    bit          hit;
    bit          err;
    logic [31:0] va;
    int          lat;
    int          cyc;
    int          reads;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_addr_q[$];
  int n_cmp = 0, n_fail = 0;
  int negcount = 0, done_seen = 0, reads_cnt = 0;
  bit ignore_addr = 1'b0;
  exp_t mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] pkt_hash(input int n, input int off);
    logic [63:0] k;
    k = '0;
    for (int i = 0; i < n; i++) k[63-8*i -: 8] = mem[14+off+i];
    return k[63:48] ^ k[47:32] ^ k[31:16] ^ k[15:0];
  endfunction

  // Reference lookup: probes the table array directly, queues expected reads.
  task automatic model(input int n, input int off, input int base, input int mask,
                       input int stride, output exp_t e);
    logic [15:0] h;
    int probes;
    int ea;
    bit same;
    e.hit = 0; e.err = 0; e.va = '0; e.reads = 0; e.cyc = 0;
    if (n < 1 || n > 8) begin
      e.err = 1; e.lat = 1;
      return;
    end
    for (int i = 0; i < n; i++) exp_addr_q.push_back(32'(14 + off + i));
    h = pkt_hash(n, off);
    probes = 0;
    for (int p = 0; p < 4; p++) begin
      ea = base + ((int'(h) + p) & mask) * stride;
      probes++;
      for (int j = 0; j <= n; j++) exp_addr_q.push_back(32'(ea + j));
      same = 1;
      for (int j = 0; j < n; j++) if (mem[ea+1+j] != mem[14+off+j]) same = 0;
      if (mem[ea] != 0 && same) begin
        e.hit = 1; e.va = 32'(ea + 1 + n);
        break;
      end
      if (mem[ea] == 0) break;
    end
    e.lat   = (probes + 1) * (n + 3);
    e.reads = n + probes * (n + 1);
  endtask

  // Monitor: read addresses and completions against the scoreboard.
  always @(negedge clk) begin
    negcount++;
    if (!rst) begin
      if (mem_ce_o && !ignore_addr) begin
        reads_cnt++;
        if (exp_addr_q.size() == 0) check("spurious_read", 64'(mem_ce_o), 64'd0);
        else check("read_addr", 64'(mem_addr_o), 64'(exp_addr_q.pop_front()));
      end
      if (done_o) begin
        done_seen++;
        if (exp_q.size() == 0) begin
          check("spurious_done", 64'(done_o), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("hit", 64'(hit_o), 64'(mon_e.hit));
          check("err", 64'(err_o), 64'(mon_e.err));
          check("val_addr", 64'(val_addr_o), 64'(mon_e.va));
          check("done_cycle", 64'(negcount), 64'(mon_e.cyc));
          check("read_count", 64'(reads_cnt), 64'(mon_e.reads));
        end
        reads_cnt = 0;
      end
    end
  end

  task automatic set_cfg(input int n, input int off, input int base, input int mask, input int stride);
    cfg_key_len_i   = 4'(n);
    cfg_key_off_i   = 6'(off);
    cfg_base_i      = 32'(base);
    cfg_mask_i      = 16'(mask);
    cfg_entry_len_i = 8'(stride);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 400 && done_seen < target; i++) @(posedge clk);
    check("done_seen", 64'(done_seen), 64'(target));
  endtask

  // Issue one lookup; optionally pulse a conflicting start 'poke' cycles in.
  task automatic lookup(input int n, input int off, input int base, input int mask,
                        input int stride, input int poke);
    exp_t e;
    int seen0;
    @(posedge clk); #1;
    set_cfg(n, off, base, mask, stride);
    model(n, off, base, mask, stride, e);
    e.cyc = negcount + 1 + e.lat;
    exp_q.push_back(e);
    seen0 = done_seen;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    if (poke > 0) begin
      repeat (poke - 1) @(posedge clk);
      #1;
      start_i = 1'b1;
      cfg_key_len_i = 4'd2;
      cfg_base_i = cfg_base_i ^ 32'h40;
      cfg_key_off_i = cfg_key_off_i + 6'd1;
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    wait_done(seen0 + 1);
  endtask

  task automatic clear_table();
    for (int a = 256; a < 1024; a++) mem[a] = 8'd0;
  endtask

  task automatic put_pkt4(input int off, input logic [31:0] key);
    for (int i = 0; i < 4; i++) mem[14+off+i] = key[31-8*i -: 8];
  endtask

  task automatic put_entry4(input int ea, input logic [7:0] v, input logic [31:0] key);
    mem[ea] = v;
    for (int i = 0; i < 4; i++) mem[ea+1+i] = key[31-8*i -: 8];
    mem[ea+5] = 8'hA5;
  endtask

  int b, mask_r, n_r, off_r, stride_r, seen0;
  exp_t e1, e2;

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 8'd0;
    rst = 1'b1; start_i = 1'b0;
    set_cfg(0, 0, 0, 0, 0);

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_ce", 64'(mem_ce_o), 0);
    check("rst_mem_addr", 64'(mem_addr_o), 0);
    check("rst_busy", 64'(busy_o), 0);
    check("rst_done", 64'(done_o), 0);
    check("rst_hit", 64'(hit_o), 0);
    check("rst_err", 64'(err_o), 0);
    check("rst_val", 64'(val_addr_o), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Hit on first probe.
    put_pkt4(16, 32'h0A000001);
    clear_table();
    b = int'(pkt_hash(4, 16)) & 15;
    put_entry4(256 + b*8, 8'd1, 32'h0A000001);
    lookup(4, 16, 256, 15, 8, 0);

    // Collision: probe 0 holds a different key, probe 1 matches.
    clear_table();
    put_entry4(256 + b*8, 8'd1, 32'h0A000002);
    put_entry4(256 + ((b+1)&15)*8, 8'd3, 32'h0A000001);
    lookup(4, 16, 256, 15, 8, 0);

    // Empty slot terminates even when the key bytes match.
    clear_table();
    put_entry4(256 + b*8, 8'd0, 32'h0A000001);
    put_entry4(256 + ((b+1)&15)*8, 8'd1, 32'h0A000001);
    lookup(4, 16, 256, 15, 8, 0);

    // Wrap and exhaustion: bucket 3, then 0, 1, 2, all valid, no match.
    put_pkt4(16, 32'h0A000003);
    clear_table();
    for (int k = 0; k < 4; k++) put_entry4(256 + k*8, 8'd1, 32'h0B000000 + 32'(k));
    lookup(4, 16, 256, 3, 8, 0);

    // Bad key lengths.
    lookup(0, 16, 256, 3, 8, 0);
    lookup(9, 16, 256, 3, 8, 0);
    lookup(15, 5, 256, 3, 8, 0);

    // Start pulsed mid-lookup is ignored.
    put_pkt4(16, 32'h0A000001);
    clear_table();
    put_entry4(256 + b*8, 8'd1, 32'h0A000001);
    lookup(4, 16, 256, 15, 8, 5);

    // Reset at cycle 8 aborts the lookup.
    @(posedge clk); #1;
    set_cfg(4, 16, 256, 15, 8);
    ignore_addr = 1'b1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_mem_ce", 64'(mem_ce_o), 0);
    check("abort_busy", 64'(busy_o), 0);
    check("abort_done", 64'(done_o), 0);
    check("abort_hit", 64'(hit_o), 0);
    check("abort_err", 64'(err_o), 0);
    check("abort_val", 64'(val_addr_o), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_addr_q.delete();
    reads_cnt = 0;
    ignore_addr = 1'b0;
    repeat (30) @(posedge clk);

    // Fresh lookup after the abort.
    lookup(4, 16, 256, 15, 8, 0);

    // Start held high re-triggers right after DONE.
    @(posedge clk); #1;
    set_cfg(4, 16, 256, 15, 8);
    model(4, 16, 256, 15, 8, e1);
    e1.cyc = negcount + 1 + e1.lat;
    exp_q.push_back(e1);
    model(4, 16, 256, 15, 8, e2);
    e2.cyc = e1.cyc + 1 + e2.lat;
    exp_q.push_back(e2);
    seen0 = done_seen;
    start_i = 1'b1;
    wait_done(seen0 + 1);
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_done(seen0 + 2);

    // Randomised lookups over a small byte alphabet.
    for (int t = 0; t < 40; t++) begin
      for (int a = 14; a < 14 + 64 + 8; a++) mem[a] = 8'($urandom_range(0, 3));
      n_r = ($urandom_range(0, 7) == 0) ? ((($urandom_range(0, 1)) == 0) ? 0 : int'($urandom_range(9, 15)))
                                        : int'($urandom_range(1, 8));
      off_r = $urandom_range(0, 63);
      mask_r = (1 << $urandom_range(0, 4)) - 1;
      stride_r = (n_r >= 1 && n_r <= 8) ? int'($urandom_range(n_r + 2, 16)) : 16;
      clear_table();
      if (n_r >= 1 && n_r <= 8) begin
        for (int k = 0; k <= mask_r; k++) begin
          int ea;
          bit copy;
          ea = 256 + k * stride_r;
          mem[ea] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
          copy = ($urandom_range(0, 2) == 0);
          for (int j = 0; j < n_r; j++)
            mem[ea+1+j] = copy ? mem[14+off_r+j] : 8'($urandom_range(0, 3));
          mem[ea+1+n_r] = 8'($urandom);
        end
      end
      lookup(n_r, off_r, 256, mask_r, stride_r, 0);
    end

    repeat (5) @(posedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete (compared %0d, mismatched %0d)", n_cmp, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/multi_way_matcher.md
Name: multi_way_matcher

Overview:
- Parametrised exact-match lookup engine; next generation of the single-table byte matcher.
- Extracts a key of runtime-configurable length and offset from packet memory.
- Hashes the key internally, then linearly probes up to WAYS consecutive table entries for a matching valid entry.
- Sits between the parser/pipeline controller and the action stage; on a hit, returns the address of the matching entry's value field.

Parameters:
ADDR_W, 32, address width of memory port and table config
KEY_MAX, 8, maximum key length in bytes (1..8)
WAYS, 4, maximum probes per lookup (>=1)
HASH_W, 16, hash/bucket index width
PKT_BASE, 14, byte address where the L3 header starts in packet memory

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
start_i  in  1  lookup request; sampled only in IDLE
cfg_key_off_i  in  6  key byte offset from PKT_BASE; sampled at start
cfg_key_len_i  in  4  key length in bytes; sampled at start
cfg_entry_len_i  in  8  entry stride in bytes; sampled at start
cfg_base_i  in  ADDR_W  table base address; sampled at start
cfg_mask_i  in  HASH_W  bucket mask (table size minus 1, power of two); sampled at start
mem_ce_o  out  1  memory read enable
mem_addr_o  out  ADDR_W  byte read address
mem_data_i  in  8  read byte; valid one cycle after a cycle with mem_ce_o=1
busy_o  out  1  lookup in progress (state != IDLE)
done_o  out  1  one-cycle completion pulse
hit_o  out  1  lookup result; valid from done_o, held until next accepted start
err_o  out  1  bad key length; valid from done_o, held until next accepted start
val_addr_o  out  ADDR_W  value address on hit, else 0; held like hit_o

Behaviour:
- Reset values: all outputs 0; all internal key/entry byte registers 0; state IDLE.
- Reset mid-lookup aborts immediately.
- No done_o is emitted after reset; mem_ce_o drops the next cycle.
- Entry layout at address E: byte E = valid flag (nonzero = valid); bytes E+1..E+n = key; value at E+1+n.
- Here n is the sampled key length.
- Key byte i is read from PKT_BASE + cfg_key_off + i.
- Packed key K = key[0] in bits 63:56 ... key[7] in bits 7:0; unused bytes are 0.
- Hash h = XOR of the 64/HASH_W HASH_W-bit slices of K.
- Probe p (0-based) entry address = cfg_base + (((h + p) & cfg_mask) * cfg_entry_len), truncated to ADDR_W. The index wraps within the table.
- States and transitions:
  - IDLE: on start_i=1, latch cfg, clear hit/err/val_addr, assert busy_o.
    - If n==0 or n>KEY_MAX, go to DONE with err_o=1, hit_o=0, and no memory access.
    - Otherwise go to LOAD_KEY.
  - LOAD_KEY: n+1 cycles.
    - Issue address j in cycle j (j < n) with mem_ce_o=1.
    - Capture mem_data_i into key[j-1] in cycle j (j >= 1).
    - mem_ce_o=0 in the last cycle.
  - HASH: 1 cycle; compute h; p=0.
  - LOAD_ENTRY: n+2 cycles; reads valid byte then n key bytes, with the same issue/capture pipeline as LOAD_KEY.
  - COMPARE: 1 cycle; the three cases are evaluated in this order:
    - Valid and all n bytes equal: hit_o=1, val_addr_o = E+1+n, go to DONE.
    - Valid flag 0: miss, go to DONE (empty slot terminates the search).
    - Otherwise, if p+1 < WAYS: p++ and go to LOAD_ENTRY. Else miss, go to DONE.
    - A miss leaves hit_o=0 and val_addr_o=0.
  - DONE: done_o=1 for exactly this cycle, busy_o=0 from the next cycle, return to IDLE.
- Latency: with P probes used, done_o is asserted in cycle (P+1)*(n+3), counting from the start-sampling cycle as 0. With an error, done_o is asserted in cycle 1.
- start_i while busy_o=1 is ignored; it is not queued.
- start_i held high re-triggers a new lookup in the cycle after DONE.
- Only bytes 0..n-1 take part in the compare.
- mem_ce_o is 0 in IDLE, HASH, COMPARE and DONE.
- mem_addr_o is don't-care when mem_ce_o=0.

Test Plan:
- Hit on first probe: n=4, off=16, key bytes at 30..33 = 0A 00 00 01. Entry at the bucket has valid=1 and the same key -> done_o at cycle 14, hit_o=1, val_addr_o = E+5.
- Collision: probe 0 holds a valid different key, probe 1 holds a match -> done_o at cycle 21, hit_o=1, val_addr_o = E1+5.
- Empty slot: probe 0 has valid=0 -> done_o at cycle 14, hit_o=0, val_addr_o=0.
- Wrap and exhaustion: cfg_mask=3, h&3 = 3, WAYS=4, all valid, no match. Probe addresses must be buckets 3, 0, 1, 2 -> done_o at cycle 35 (n=4), hit_o=0.
- Bad length: cfg_key_len=0 and cfg_key_len=9 -> no mem_ce_o, done_o at cycle 1, err_o=1, hit_o=0.
- Robustness:
  - start_i pulsed during a lookup -> ignored.
  - rst asserted at cycle 8 of a lookup -> all outputs 0 the next cycle, no done_o.
  - A fresh start_i after that completes correctly.
